// File: rtl/demux_1_3_reg_if.sv
// Stream bundle between a single source and the three-channel demux.
// The master side offers words and sinks channels; the slave side is the demux.
interface demux_1_3_reg_if #(
    parameter int WIDTH = 3
);
    logic [1:0]       s;
    logic [WIDTH-1:0] d;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [2:0]       y_valid;
    logic [2:0]       y_ready;

    modport master (
        output s, d, in_valid, y_ready,
        input  in_ready, y0, y1, y2, y_valid
    );

    modport slave (
        input  s, d, in_valid, y_ready,
        output in_ready, y0, y1, y2, y_valid
    );
endinterface

// File: rtl/demux_1_3_reg.sv
// Registered 1-to-3 stream demultiplexer. Each channel owns a one-entry
// holding register so a stalled sink never blocks the other channels.
// Select code 3 is illegal: such words are consumed, flagged and counted.
module demux_1_3_reg #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    demux_1_3_reg_if.slave   bus,
    input  logic             err_clr,
    output logic             err,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [2:0][WIDTH-1:0] r_q;
    logic [2:0]            v_q;
    logic [2:0]            sel;
    logic                  illegal;
    logic                  accept;
    logic [2:0]            load;
    logic                  drop;
    logic                  in_ready;

    // Decode the select and decide whether the addressed slot can take a word;
    // an illegal select is always accepted so the bad word is simply consumed.
    always_comb begin
        sel      = 3'b000;
        illegal  = 1'b0;
        case (bus.s)
            2'b00:   sel = 3'b001;
            2'b01:   sel = 3'b010;
            2'b10:   sel = 3'b100;
            default: illegal = 1'b1;
        endcase
        in_ready = illegal | (|(sel & (~v_q | bus.y_ready)));
        accept   = bus.in_valid & in_ready;
        load     = sel & {3{accept}};
        drop     = accept & illegal;
    end

    // Per-channel holding registers: a load wins over a drain so that a
    // drained-and-refilled slot stays valid and sustains one word per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            v_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load[i]) begin
                    r_q[i] <= bus.d;
                    v_q[i] <= 1'b1;
                end else if (bus.y_ready[i]) begin
                    v_q[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky error flag and saturating drop counter; a clear in the same
    // cycle as an illegal accept wins, so that word goes uncounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            drop_cnt <= '0;
        end else if (err_clr) begin
            err      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            err <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.y0       = r_q[0];
    assign bus.y1       = r_q[1];
    assign bus.y2       = r_q[2];
    assign bus.y_valid  = v_q;

endmodule

// File: tb/tb_demux_1_3_reg.sv
// Self-checking bench for demux_1_3_reg: directed scenarios plus random
// traffic, all compared against a queue-based model of the channels.
module tb_demux_1_3_reg;

    localparam int WIDTH = 3;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             err_clr = 1'b0;
    logic             err;
    logic [CNT_W-1:0] drop_cnt;

    demux_1_3_reg_if #(.WIDTH(WIDTH)) bus ();

    demux_1_3_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .err_clr  (err_clr),
        .err      (err),
        .drop_cnt (drop_cnt)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] chan_q [3][$];
    logic [WIDTH-1:0] last_word [3];
    logic             err_model;
    int               drop_model;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            chan_q[i].delete();
            last_word[i] = '0;
        end
        err_model  = 1'b0;
        drop_model = 0;
    endtask

    function automatic logic expReady(input logic [1:0] s, input logic [2:0] yr);
        if (s == 2'd3) return 1'b1;
        return (chan_q[s].size() == 0) || yr[s];
    endfunction

    task automatic checkState(input string phase);
        logic [2:0] vexp;
        for (int i = 0; i < 3; i++) vexp[i] = (chan_q[i].size() != 0);
        checkOutput({phase, ".y_valid"}, 32'(bus.y_valid), 32'(vexp));
        checkOutput({phase, ".y0"}, 32'(bus.y0), 32'(last_word[0]));
        checkOutput({phase, ".y1"}, 32'(bus.y1), 32'(last_word[1]));
        checkOutput({phase, ".y2"}, 32'(bus.y2), 32'(last_word[2]));
        checkOutput({phase, ".err"}, 32'(err), 32'(err_model));
        checkOutput({phase, ".drop_cnt"}, 32'(drop_cnt), 32'(drop_model));
    endtask

    // Called just after a rising edge: drive, check in_ready, clock, update model, check outputs.
    task automatic applyStimulus(input logic [1:0] s, input logic [WIDTH-1:0] d, input logic valid,
                                 input logic [2:0] yr, input logic clr);
        logic rdy;
        bus.s        = s;
        bus.d        = d;
        bus.in_valid = valid;
        bus.y_ready  = yr;
        err_clr      = clr;
        #2;
        rdy = expReady(s, yr);
        checkOutput("in_ready", 32'(bus.in_ready), 32'(rdy));
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (yr[i] && chan_q[i].size() != 0) void'(chan_q[i].pop_front());
        end
        if (valid && rdy) begin
            if (s != 2'd3) begin
                chan_q[s].push_back(d);
                last_word[s] = d;
            end else if (!clr) begin
                err_model  = 1'b1;
                drop_model = (drop_model < CNT_MAX) ? drop_model + 1 : CNT_MAX;
            end
        end
        if (clr) begin
            err_model  = 1'b0;
            drop_model = 0;
        end
        #1;
        checkState("cycle");
    endtask

    initial begin
        bus.s        = 2'd0;
        bus.d        = '0;
        bus.in_valid = 1'b0;
        bus.y_ready  = 3'b000;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkState("reset");
        checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First word into channel 1, then probe in_ready for both selects.
        applyStimulus(2'd1, 3'b101, 1'b1, 3'b000, 1'b0);
        checkOutput("first.y_valid", 32'(bus.y_valid), 32'b010);
        checkOutput("first.y1", 32'(bus.y1), 32'b101);
        applyStimulus(2'd1, 3'b000, 1'b0, 3'b000, 1'b0);
        applyStimulus(2'd0, 3'b000, 1'b0, 3'b000, 1'b0);

        // Backpressure on channel 2, then drain and refill in the same edge.
        applyStimulus(2'd2, 3'b011, 1'b1, 3'b000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'd2, 3'b110, 1'b1, 3'b000, 1'b0);
            checkOutput("bp.y2", 32'(bus.y2), 32'b011);
        end
        applyStimulus(2'd2, 3'b110, 1'b1, 3'b100, 1'b0);
        checkOutput("bp.refill.y2", 32'(bus.y2), 32'b110);
        checkOutput("bp.refill.v2", 32'(bus.y_valid[2]), 32'd1);

        // Drain everything, then stream 0..7 into channel 0.
        applyStimulus(2'd0, 3'b000, 1'b0, 3'b111, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(2'd0, 3'(k), 1'b1, 3'b111, 1'b0);
            checkOutput("stream.y0", 32'(bus.y0), 32'(k));
        end
        applyStimulus(2'd0, 3'b000, 1'b0, 3'b111, 1'b0);

        // Illegal selects, then a clear racing a fourth illegal accept.
        for (int k = 0; k < 3; k++) applyStimulus(2'd3, 3'(k), 1'b1, 3'b000, 1'b0);
        checkOutput("illegal.cnt", 32'(drop_cnt), 32'd3);
        checkOutput("illegal.err", 32'(err), 32'd1);
        applyStimulus(2'd3, 3'b111, 1'b1, 3'b000, 1'b1);
        checkOutput("clr.cnt", 32'(drop_cnt), 32'd0);
        checkOutput("clr.err", 32'(err), 32'd0);

        // Saturation of the drop counter.
        for (int k = 0; k < 260; k++) applyStimulus(2'd3, 3'(k), 1'b1, 3'b000, 1'b0);
        checkOutput("sat.cnt", 32'(drop_cnt), 32'd255);
        applyStimulus(2'd0, 3'b000, 1'b0, 3'b000, 1'b1);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)),
                          1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
                          ($urandom_range(15, 0) == 0));
        end

        // Fill all three channels, then pulse reset between edges.
        applyStimulus(2'd0, 3'b000, 1'b0, 3'b111, 1'b0);
        applyStimulus(2'd0, 3'b001, 1'b1, 3'b000, 1'b0);
        applyStimulus(2'd1, 3'b010, 1'b1, 3'b000, 1'b0);
        applyStimulus(2'd2, 3'b100, 1'b1, 3'b000, 1'b0);
        applyStimulus(2'd3, 3'b000, 1'b1, 3'b000, 1'b0);
        checkOutput("full.y_valid", 32'(bus.y_valid), 32'b111);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkState("async");
        checkOutput("async.y_valid", 32'(bus.y_valid), 32'd0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkState("post_reset");
        applyStimulus(2'd1, 3'b111, 1'b1, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1_3_reg.md
# demux_1_3_reg

Registered 1-to-3 stream demultiplexer, the distribution-side counterpart of the 3:1 selector `mux_3_1_case`. Each accepted input word goes to one of three output channels, chosen by a 2-bit select. Every channel has a one-entry holding register with a valid/ready handshake, so a stalled sink does not block traffic to the other channels. Select code 2'b11 is illegal: the word is dropped, flagged and counted.

## Interface
- WIDTH, 3, data word width in bits
- CNT_W, 8, width of the drop counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s  in  2  destination select for the current input word; 2'b00 goes to channel 0, 2'b01 to channel 1, 2'b10 to channel 2, 2'b11 is illegal
- d  in  WIDTH  input data word
- in_valid  in  1  input word and s are valid
- in_ready  out  1  block can accept the input this cycle
- y0, y1, y2  out  WIDTH  channel data, driven from the holding registers
- y_valid  out  3  bit i means channel i holds a word
- y_ready  in  3  bit i means the sink of channel i takes the word this cycle
- err_clr  in  1  synchronous clear of err and drop_cnt
- err  out  1  sticky flag; set when a word with s == 2'b11 is accepted
- drop_cnt  out  CNT_W  saturating count of dropped words

## Operation
- Per-channel state: data register r_i[WIDTH-1:0] and valid bit v_i. y_i = r_i and y_valid[i] = v_i.
- in_ready is combinational:
  - 1 when s == 2'b11.
  - Otherwise ~v_s | y_ready[s], meaning the target slot is empty or is being drained this cycle.
  - It does not depend on in_valid.
- Accept: in_valid & in_ready at a rising edge.
- Legal s on accept: r_s <= d and v_s <= 1. Other channels are unaffected.
- Illegal s on accept: no channel changes, err <= 1, and drop_cnt increments. drop_cnt saturates at 2^CNT_W-1 and does not wrap.
- Drain: when v_i & y_ready[i] and there is no accept into channel i that cycle, v_i <= 0. r_i keeps its old value; it is don't-care while invalid.
- Simultaneous drain and accept on the same channel: v_i stays 1 and r_i takes the new d. This gives one word per cycle per channel.
- Drains on different channels, and an accept into a different channel, proceed independently in the same cycle.
- y_ready[i] while v_i == 0 has no effect.
- err_clr: err <= 0 and drop_cnt <= 0.
  - err_clr has priority over a same-cycle illegal accept. The dropped word is still consumed (in_ready = 1), but it is not counted.
- Output stability: while v_i == 1 and y_ready[i] == 0, y_i and y_valid[i] must hold unchanged.
- No other state exists. The block has no FSM beyond the per-channel valid bits.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - v_i = 0, so y_valid = 3'b000
  - r_i = 0, so y0 = y1 = y2 = 0
  - err = 0
  - drop_cnt = 0
- in_ready follows from these values; with all slots empty it reads 1.
- Release of rst_n is sampled synchronously; the first accept is possible on the first rising edge after release.
- Latency: a word accepted at edge N appears with y_valid[i] = 1 after edge N, i.e. in cycle N+1.
- Throughput: one word per cycle in total. A continuously ready channel sustains 1 word/cycle.
- Reset mid-operation: every held word is lost and all outputs return to their reset values immediately, without waiting for a clock edge.
- Combinational paths: y_ready and s to in_ready. There is no path from in_valid to any output, and no path from d to any output.

## Test plan
- Reset, then d=3'b101, s=2'b01, in_valid=1 for one cycle with y_ready=3'b000:
  - In cycle N+1, y_valid=3'b010 and y1=3'b101.
  - in_ready=0 for s=2'b01 and in_ready=1 for s=2'b00.
- Backpressure: channel 2 holds 3'b011 with y_ready[2]=0. Offer d=3'b110, s=2'b10 for 5 cycles:
  - in_ready stays 0, and y2 stays 3'b011 throughout.
  - Raise y_ready[2]: the same edge drains 3'b011 and loads 3'b110, and y_valid[2] stays 1.
- Streaming: s=2'b00, d=0..7 on consecutive cycles, in_valid=1, y_ready=3'b111:
  - y0 shows 0..7 on consecutive cycles, one cycle late, with no gaps.
  - in_ready stays 1.
- Illegal select: 3 accepts with s=2'b11:
  - y_valid stays unchanged, err=1, drop_cnt=3.
  - Pulse err_clr in the same cycle as a 4th illegal accept: err=0 and drop_cnt=0 afterwards.
- Saturation: 260 illegal accepts with CNT_W=8 leave drop_cnt=255.
- Async reset: with all three channels valid, pulse rst_n low for half a cycle between edges:
  - y_valid=3'b000 and y0=y1=y2=0 immediately.
  - err=0 and drop_cnt=0.
